// File: rtl/ifetch32.sv
// Instruction-fetch front end: owns the fetch PC, hides the ROM's one-cycle read
// latency, and hands words to decode through a 2-entry buffer with bypass.
module ifetch32 #(
  parameter int                  ADDR_WIDTH = 5,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_instr,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [PC_WIDTH-1:0]   out_pc
);

  logic [PC_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]      inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               count_q, count_d;
  logic                     head_q, head_d;
  logic [1:0][31:0]         fifo_instr_q;
  logic [1:0][PC_WIDTH-1:0] fifo_pc_q;

  logic       fire, issue, push, pop, wr_idx;
  logic [2:0] occ;

  assign imem_addr = fetch_pc_q[ADDR_WIDTH+1:2];
  assign out_valid = (count_q != 2'd0) || inflight_q;
  assign out_instr = (count_q != 2'd0) ? fifo_instr_q[head_q] : imem_instr;
  assign out_pc    = (count_q != 2'd0) ? fifo_pc_q[head_q]    : inflight_pc_q;

  assign fire   = out_valid && out_ready;
  // Occupancy after this cycle's pop; issuing only when <=1 keeps the buffer
  // from ever needing a third slot for the word returning next cycle.
  assign occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fire};
  assign issue  = !redirect_valid && (occ <= 3'd1);
  assign push   = inflight_q && !((count_q == 2'd0) && fire);
  assign pop    = fire && (count_q != 2'd0);
  assign wr_idx = head_q ^ count_q[0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    head_d        = head_q ^ pop;
    if (issue) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_WIDTH'(4);
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
      head_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      fifo_instr_q  <= '0;
      fifo_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      head_q        <= head_d;
      if (push && !redirect_valid) begin
        fifo_instr_q[wr_idx] <= imem_instr;
        fifo_pc_q[wr_idx]    <= inflight_pc_q;
      end
    end
  end

endmodule
